intercpu_cluster_regs: RTL and testbench

INTERCPU_CLUSTER_REGS -- requirements
Module: intercpu_cluster_regs

---
 rtl/intercpu_pkg.sv | 11 +
 rtl/intercpu_rr_arb.sv | 30 +++
 rtl/intercpu_cluster_regs.sv | 73 +++++++
 tb/tb_intercpu_cluster_regs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intercpu_pkg.sv
// intercpu_pkg: sizes, op codes and arbiter states shared by the inter-CPU cluster registers.
package intercpu_pkg;
  localparam int ST_COUNT = 8;
  localparam int ST_WIDTH = 64;
  localparam int SM_COUNT = 32;
  localparam logic [1:0] OP_ST  = 2'b00;
  localparam logic [1:0] OP_TAS = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  typedef enum logic [1:0] {IDLE, ACK_A, ACK_B} arb_state_e;
endpackage

// File: rtl/intercpu_rr_arb.sv
// intercpu_rr_arb: 2-port round-robin arbiter; the state register doubles as the registered acks.
module intercpu_rr_arb import intercpu_pkg::*; (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o,
  output logic ack_a_o,
  output logic ack_b_o
);
  arb_state_e state_q;
  logic ptr_q;
  logic elig_a, elig_b;
  assign ack_a_o = state_q == ACK_A;
  assign ack_b_o = state_q == ACK_B;
  assign elig_a  = req_a_i & ~ack_a_o;
  assign elig_b  = req_b_i & ~ack_b_o;
  // ptr_q low means A owns the tie-break
  assign gnt_a_o = elig_a & (~elig_b | ~ptr_q);
  assign gnt_b_o = elig_b & (~elig_a | ptr_q);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= gnt_a_o ? ACK_A : gnt_b_o ? ACK_B : IDLE;
      if (gnt_a_o | gnt_b_o) ptr_q <= gnt_a_o;
    end
endmodule

// File: rtl/intercpu_cluster_regs.sv
// intercpu_cluster_regs: shared ST registers and optional semaphores (CRAY_ST_SEMAPHORE_EN) for two CPUs.
module intercpu_cluster_regs import intercpu_pkg::*; (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_req_a,
  input  logic [1:0]                   i_op_a,
  input  logic [4:0]                   i_idx_a,
  input  logic [63:0]                  i_data_a,
  output logic                         o_ack_a,
  output logic                         o_fail_a,
  input  logic                         i_req_b,
  input  logic [1:0]                   i_op_b,
  input  logic [4:0]                   i_idx_b,
  input  logic [63:0]                  i_data_b,
  output logic                         o_ack_b,
  output logic                         o_fail_b,
  output logic [ST_COUNT*ST_WIDTH-1:0] o_st
`ifdef CRAY_ST_SEMAPHORE_EN
  ,
  output logic [SM_COUNT-1:0]          o_sm
`endif
);
  logic gnt_a, gnt_b, go;
  logic [1:0] op;
  logic [4:0] idx;
  logic [ST_WIDTH-1:0] data;
  logic [ST_COUNT-1:0][ST_WIDTH-1:0] st_q;
  intercpu_rr_arb u_arb (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .req_a_i (i_req_a),
    .req_b_i (i_req_b),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b),
    .ack_a_o (o_ack_a),
    .ack_b_o (o_ack_b)
  );
  assign go   = gnt_a | gnt_b;
  assign op   = gnt_b ? i_op_b : i_op_a;
  assign idx  = gnt_b ? i_idx_b : i_idx_a;
  assign data = gnt_b ? i_data_b : i_data_a;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) st_q <= '0;
    else if (go && op == OP_ST) st_q[idx[2:0]] <= data;
  assign o_st = st_q;
`ifdef CRAY_ST_SEMAPHORE_EN
  logic [SM_COUNT-1:0] sm_q, sm_d;
  logic fail_q, fail_d;
  always_comb begin
    sm_d   = sm_q;
    fail_d = go && op == OP_TAS && sm_q[idx];
    if (go && op == OP_TAS) sm_d[idx] = 1'b1;
    if (go && op == OP_CLR) sm_d[idx] = 1'b0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sm_q   <= '0;
      fail_q <= 1'b0;
    end else begin
      sm_q   <= sm_d;
      fail_q <= fail_d;
    end
  // only one ack is ever high, so a single fail flag serves both ports
  assign o_fail_a = o_ack_a & fail_q;
  assign o_fail_b = o_ack_b & fail_q;
  assign o_sm     = sm_q;
`else
  logic unused_idx;
  assign unused_idx = ^idx[4:3];
  assign o_fail_a = 1'b0;
  assign o_fail_b = 1'b0;
`endif
endmodule

// File: tb/tb_intercpu_cluster_regs.sv
// tb_intercpu_cluster_regs: directed checks of ST writes, arbitration, semaphores and reset.
module tb_intercpu_cluster_regs;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_req_a = 1'b0, i_req_b = 1'b0;
  logic [1:0] i_op_a = '0, i_op_b = '0;
  logic [4:0] i_idx_a = '0, i_idx_b = '0;
  logic [63:0] i_data_a = '0, i_data_b = '0;
  logic o_ack_a, o_fail_a, o_ack_b, o_fail_b;
  logic [511:0] o_st;
`ifdef CRAY_ST_SEMAPHORE_EN
  logic [31:0] o_sm;
`endif
  int checks = 0, failures = 0;

  intercpu_cluster_regs dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_a(i_req_a), .i_op_a(i_op_a), .i_idx_a(i_idx_a), .i_data_a(i_data_a),
    .o_ack_a(o_ack_a), .o_fail_a(o_fail_a),
    .i_req_b(i_req_b), .i_op_b(i_op_b), .i_idx_b(i_idx_b), .i_data_b(i_data_b),
    .o_ack_b(o_ack_b), .o_fail_b(o_fail_b),
    .o_st(o_st)
`ifdef CRAY_ST_SEMAPHORE_EN
    , .o_sm(o_sm)
`endif
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    i_req_a = 1'b0;
    i_req_b = 1'b0;
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic issue(input logic port, input logic [1:0] op, input logic [4:0] idx,
                       input logic [63:0] data, output int lat, output logic fail);
    int n = 0;
    lat  = 0;
    fail = 1'b0;
    @(negedge i_clk);
    if (port) begin
      i_req_b = 1'b1; i_op_b = op; i_idx_b = idx; i_data_b = data;
    end else begin
      i_req_a = 1'b1; i_op_a = op; i_idx_a = idx; i_data_a = data;
    end
    while (lat == 0 && n < 8) begin
      @(negedge i_clk);
      n++;
      if (port ? o_ack_b : o_ack_a) begin
        lat  = n;
        fail = port ? o_fail_b : o_fail_a;
      end
    end
    i_req_a = 1'b0;
    i_req_b = 1'b0;
  endtask

  task automatic issue_pair(input logic [1:0] opa, input logic [4:0] idxa, input logic [63:0] da,
                            input logic [1:0] opb, input logic [4:0] idxb, input logic [63:0] db,
                            output int la, output int lb, output logic fa, output logic fb);
    int n = 0;
    la = 0; lb = 0; fa = 1'b0; fb = 1'b0;
    @(negedge i_clk);
    i_req_a = 1'b1; i_op_a = opa; i_idx_a = idxa; i_data_a = da;
    i_req_b = 1'b1; i_op_b = opb; i_idx_b = idxb; i_data_b = db;
    while ((la == 0 || lb == 0) && n < 8) begin
      @(negedge i_clk);
      n++;
      if (o_ack_a && la == 0) begin la = n; fa = o_fail_a; i_req_a = 1'b0; end
      if (o_ack_b && lb == 0) begin lb = n; fb = o_fail_b; i_req_b = 1'b0; end
    end
    i_req_a = 1'b0;
    i_req_b = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge i_clk);
    checks++;
    if ({o_ack_a, o_ack_b, o_fail_a, o_fail_b} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {o_ack_a, o_ack_b, o_fail_a, o_fail_b});
    end
    checks++;
    if (o_st !== 512'b0) begin failures++; $display("FAIL reset_st got=%h exp=0", o_st); end
`ifdef CRAY_ST_SEMAPHORE_EN
    checks++;
    if (o_sm !== 32'b0) begin failures++; $display("FAIL reset_sm got=%h exp=0", o_sm); end
`endif
    i_rst_n = 1'b1;
  endtask

  task automatic test_st_write;
    int lat;
    logic fail;
    logic [511:0] exp;
    do_reset();
    exp = '0;
    exp[255:192] = 64'h0123456789ABCDEF;
    issue(1'b0, 2'b00, 5'b11011, 64'h0123456789ABCDEF, lat, fail);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL st_write_latency got=%0d exp=1", lat); end
    checks++;
    if (fail !== 1'b0) begin failures++; $display("FAIL st_write_fail got=%b exp=0", fail); end
    checks++;
    if (o_st !== exp) begin failures++; $display("FAIL st_write_value got=%h exp=%h", o_st, exp); end
    @(negedge i_clk);
    checks++;
    if (o_ack_a !== 1'b0) begin failures++; $display("FAIL st_write_ack_pulse got=%b exp=0", o_ack_a); end
  endtask

  task automatic test_back_to_back;
    int la, lb;
    logic fa, fb;
    do_reset();
    issue_pair(2'b00, 5'd0, 64'd1, 2'b00, 5'd0, 64'd2, la, lb, fa, fb);
    checks++;
    if (la !== 1 || lb !== 2) begin failures++; $display("FAIL pair1_order got=a%0d/b%0d exp=a1/b2", la, lb); end
    checks++;
    if (o_st[63:0] !== 64'd2) begin failures++; $display("FAIL pair1_st0 got=%h exp=2", o_st[63:0]); end
    issue_pair(2'b00, 5'd1, 64'hA, 2'b00, 5'd1, 64'hB, la, lb, fa, fb);
    checks++;
    if (la !== 1 || lb !== 2) begin failures++; $display("FAIL pair2_order got=a%0d/b%0d exp=a1/b2", la, lb); end
    checks++;
    if (o_st[127:64] !== 64'hB) begin failures++; $display("FAIL pair2_st1 got=%h exp=b", o_st[127:64]); end
    issue(1'b0, 2'b00, 5'd2, 64'd3, la, fa);
    issue_pair(2'b00, 5'd4, 64'h44, 2'b00, 5'd4, 64'h55, la, lb, fa, fb);
    checks++;
    if (la !== 2 || lb !== 1) begin failures++; $display("FAIL pair3_order got=a%0d/b%0d exp=a2/b1", la, lb); end
    checks++;
    if (o_st[319:256] !== 64'h44) begin failures++; $display("FAIL pair3_st4 got=%h exp=44", o_st[319:256]); end
    checks++;
    if (o_st[191:128] !== 64'd3) begin failures++; $display("FAIL single_st2 got=%h exp=3", o_st[191:128]); end
  endtask

`ifdef CRAY_ST_SEMAPHORE_EN
  task automatic test_semaphore;
    int lat;
    logic fail;
    do_reset();
    issue(1'b0, 2'b01, 5'd5, 64'd0, lat, fail);
    checks++;
    if (lat !== 1 || fail !== 1'b0) begin failures++; $display("FAIL tas_a got=lat%0d/fail%b exp=lat1/fail0", lat, fail); end
    issue(1'b1, 2'b01, 5'd5, 64'd0, lat, fail);
    checks++;
    if (lat !== 1 || fail !== 1'b1) begin failures++; $display("FAIL tas_b got=lat%0d/fail%b exp=lat1/fail1", lat, fail); end
    checks++;
    if (o_sm !== 32'h20) begin failures++; $display("FAIL tas_sm got=%h exp=00000020", o_sm); end
    @(negedge i_clk);
    checks++;
    if (o_fail_b !== 1'b0) begin failures++; $display("FAIL fail_without_ack got=%b exp=0", o_fail_b); end
    issue(1'b1, 2'b10, 5'd5, 64'd0, lat, fail);
    checks++;
    if (fail !== 1'b0 || o_sm !== 32'h0) begin failures++; $display("FAIL clr_b got=fail%b/sm%h exp=fail0/sm0", fail, o_sm); end
    issue(1'b0, 2'b11, 5'd5, 64'hFF, lat, fail);
    checks++;
    if (lat !== 1 || fail !== 1'b0 || o_sm !== 32'h0 || o_st !== 512'b0) begin
      failures++;
      $display("FAIL op11 got=lat%0d/fail%b/sm%h exp=lat1/fail0/sm0", lat, fail, o_sm);
    end
  endtask

  task automatic test_sm_race;
    int la, lb;
    logic fa, fb;
    do_reset();
    issue_pair(2'b01, 5'd31, 64'd0, 2'b01, 5'd31, 64'd0, la, lb, fa, fb);
    checks++;
    if (fa !== 1'b0 || fb !== 1'b1) begin failures++; $display("FAIL race_fail got=a%b/b%b exp=a0/b1", fa, fb); end
    checks++;
    if (o_sm !== 32'h80000000) begin failures++; $display("FAIL race_sm got=%h exp=80000000", o_sm); end
  endtask
`else
  task automatic test_no_semaphore;
    int lat;
    logic fail;
    logic [511:0] exp;
    do_reset();
    exp = '0;
    exp[447:384] = 64'h66;
    issue(1'b0, 2'b00, 5'd6, 64'h66, lat, fail);
    issue(1'b0, 2'b01, 5'd5, 64'h77, lat, fail);
    checks++;
    if (lat !== 1 || fail !== 1'b0) begin failures++; $display("FAIL nosm_tas_a got=lat%0d/fail%b exp=lat1/fail0", lat, fail); end
    checks++;
    if (o_st !== exp) begin failures++; $display("FAIL nosm_st got=%h exp=%h", o_st, exp); end
    issue(1'b1, 2'b01, 5'd5, 64'h77, lat, fail);
    checks++;
    if (lat !== 1 || fail !== 1'b0) begin failures++; $display("FAIL nosm_tas_b got=lat%0d/fail%b exp=lat1/fail0", lat, fail); end
    issue(1'b0, 2'b10, 5'd6, 64'h77, lat, fail);
    issue(1'b1, 2'b11, 5'd6, 64'h77, lat, fail);
    checks++;
    if (lat !== 1 || fail !== 1'b0 || o_st !== exp) begin failures++; $display("FAIL nosm_clr_rsv got=lat%0d/fail%b exp=lat1/fail0", lat, fail); end
  endtask
`endif

  task automatic test_reset_inflight;
    int lat;
    logic fail, seen;
    do_reset();
    issue(1'b0, 2'b00, 5'd7, 64'hDEAD, lat, fail);
    checks++;
    if (o_st[511:448] !== 64'hDEAD) begin failures++; $display("FAIL inflight_pre_st7 got=%h exp=dead", o_st[511:448]); end
    @(negedge i_clk);
    i_req_a = 1'b1; i_op_a = 2'b00; i_idx_a = 5'd0; i_data_a = 64'h5;
    @(posedge i_clk);
    #2;
    checks++;
    if (o_ack_a !== 1'b1) begin failures++; $display("FAIL inflight_pending got=%b exp=1", o_ack_a); end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_ack_a !== 1'b0 || o_fail_a !== 1'b0 || o_st !== 512'b0) begin
      failures++;
      $display("FAIL async_reset got=ack%b/fail%b/st%h exp=0", o_ack_a, o_fail_a, o_st);
    end
    i_req_a = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      seen = seen | o_ack_a | o_ack_b;
    end
    checks++;
    if (seen !== 1'b0 || o_st !== 512'b0) begin failures++; $display("FAIL post_reset_quiet got=ack%b/st%h exp=0", seen, o_st); end
  endtask

  initial begin
    test_reset();
    test_st_write();
    test_back_to_back();
`ifdef CRAY_ST_SEMAPHORE_EN
    test_semaphore();
    test_sm_race();
`else
    test_no_semaphore();
`endif
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
